// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared constants and types for the 12-button / 4-LED panel
package panel_pkg;

    localparam int N_BTN              = 12;
    localparam int N_LED              = 4;
    localparam int DEBOUNCE_1MS_50MHZ = 50000;

    typedef logic [N_BTN-1:0] btn_vec_t;

endpackage : panel_pkg

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: polarity, 2-flop sync, stability counter, events
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_next
);

    localparam logic             LP_INV  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    logic w_n;
    logic w_diff;
    logic w_done;

    assign w_n    = btn_raw ^ LP_INV;
    assign w_diff = (r_s2 != r_level);
    assign w_done = w_diff && (r_cnt == LP_TERM);

    // Exposed so the top can register the any-press OR in the same cycle as the pulses.
    assign press_next = w_done & r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= w_n;
            r_s2      <= r_s1;
            r_press   <= w_done & r_s2;
            r_release <= w_done & ~r_s2;
            // Any return to the current level restarts the stability window.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce_12.sv
// rtl/btn_debounce_12.sv - 12 independent debounced button channels plus any-press flag
module btn_debounce_12
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
    parameter int CNT_W           = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    btn_vec_t w_press_next;
    logic     r_any_press;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .press_next  (w_press_next[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_next;
        end
    end

    assign any_press = r_any_press;

endmodule : btn_debounce_12

// File: tb/tb_btn_debounce_12.sv
// tb/tb_btn_debounce_12.sv - directed self-checking bench for btn_debounce_12
module tb_btn_debounce_12;

    logic        clk;
    logic        rst_n;
    logic [11:0] btn_raw;
    logic [11:0] btn_level;
    logic [11:0] btn_press;
    logic [11:0] btn_release;
    logic        any_press;

    int n_tests;
    int n_fail;

    btn_debounce_12 #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [11:0] lvl, input logic [11:0] prs,
                           input logic [11:0] rel, input logic anyp);
        chk({tag, ".level"},   btn_level,          lvl);
        chk({tag, ".press"},   btn_press,          prs);
        chk({tag, ".release"}, btn_release,        rel);
        chk({tag, ".any"},     {11'd0, any_press}, {11'd0, anyp});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        btn_raw = 12'h000;

        // Reset with every button held: outputs stay clear until the window completes.
        step(3);
        chk_all("rst_hold", 12'h000, 12'h000, 12'h000, 1'b0);
        rst_n = 1'b1;
        step(5);
        chk_all("rst_e5", 12'h000, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("rst_e6", 12'hFFF, 12'hFFF, 12'h000, 1'b1);
        step(1);
        chk_all("rst_e7", 12'hFFF, 12'h000, 12'h000, 1'b0);

        // Release all buttons together.
        btn_raw = 12'hFFF;
        step(5);
        chk_all("relall_e5", 12'hFFF, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("relall_e6", 12'h000, 12'h000, 12'hFFF, 1'b0);
        step(1);
        chk_all("relall_e7", 12'h000, 12'h000, 12'h000, 1'b0);

        // Clean press and release on button 0.
        btn_raw = 12'hFFE;
        step(5);
        chk_all("press0_e5", 12'h000, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("press0_e6", 12'h001, 12'h001, 12'h000, 1'b1);
        step(1);
        chk_all("press0_e7", 12'h001, 12'h000, 12'h000, 1'b0);
        step(2);
        btn_raw = 12'hFFF;
        step(5);
        chk_all("rel0_e5", 12'h001, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("rel0_e6", 12'h000, 12'h000, 12'h001, 1'b0);
        step(1);
        chk_all("rel0_e7", 12'h000, 12'h000, 12'h000, 1'b0);

        // Bounce on button 3: 0,1,0,1 at 2-cycle spacing, then hold 0.
        for (int t = 0; t < 4; t++) begin
            btn_raw = (t % 2 == 0) ? 12'hFF7 : 12'hFFF;
            for (int e = 0; e < 2; e++) begin
                step(1);
                chk("bounce.press3",   {11'd0, btn_press[3]},   12'h000);
                chk("bounce.release3", {11'd0, btn_release[3]}, 12'h000);
            end
        end
        btn_raw = 12'hFF7;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            chk("bounce_hold.press3",   {11'd0, btn_press[3]},   (e == 6) ? 12'h001 : 12'h000);
            chk("bounce_hold.release3", {11'd0, btn_release[3]}, 12'h000);
            chk("bounce_hold.level3",   {11'd0, btn_level[3]},   (e >= 6) ? 12'h001 : 12'h000);
        end
        btn_raw = 12'hFFF;
        step(8);
        chk_all("bounce_rel", 12'h000, 12'h000, 12'h000, 1'b0);

        // Three-cycle glitch on button 7 must be rejected.
        btn_raw = 12'hF7F;
        step(3);
        btn_raw = 12'hFFF;
        for (int e = 0; e < 10; e++) begin
            step(1);
            chk_all("glitch7", 12'h000, 12'h000, 12'h000, 1'b0);
        end

        // Six buttons pressed on the same edge.
        btn_raw = 12'h5A5;
        step(5);
        chk_all("simul_e5", 12'h000, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("simul_e6", 12'hA5A, 12'hA5A, 12'h000, 1'b1);
        step(1);
        chk_all("simul_e7", 12'hA5A, 12'h000, 12'h000, 1'b0);
        btn_raw = 12'hFFF;
        step(8);
        chk_all("simul_rel", 12'h000, 12'h000, 12'h000, 1'b0);

        // Reset in the middle of a pending press while button 11 is already debounced.
        btn_raw = 12'h7FF;
        step(6);
        chk_all("mid_b11", 12'h800, 12'h800, 12'h000, 1'b1);
        btn_raw = 12'h7FE;
        step(4);
        chk_all("mid_pending", 12'h800, 12'h000, 12'h000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 12'h000, 12'h000, 12'h000, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk_all("mid_post_e5", 12'h000, 12'h000, 12'h000, 1'b0);
        step(1);
        chk_all("mid_post_e6", 12'h801, 12'h801, 12'h000, 1'b1);
        step(1);
        chk_all("mid_post_e7", 12'h801, 12'h000, 12'h000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_btn_debounce_12
